// File: rtl/note_lane_scheduler.sv
// Falling-note lane scheduler for a rhythm game.
// Walks a note ROM, drops each lane pattern down the screen and judges hits.
module note_lane_scheduler #(
  parameter int NUM_NOTES = 8,
  parameter int HIT_Y     = 440,
  parameter int HIT_WIN   = 10,
  parameter int END_Y     = 479
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step_tick,
  input  logic [2:0] btn,
  output logic [2:0] note_addr,
  input  logic [2:0] note_data,
  output logic [9:0] note_y,
  output logic [2:0] lane_visible,
  output logic [3:0] score,
  output logic [3:0] misses,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SPAWN = 2'b01,
    FALL  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int         WIN_LO   = HIT_Y - HIT_WIN;
  localparam int         WIN_HI   = HIT_Y + HIT_WIN;
  localparam logic [9:0] LAST_Y   = 10'(END_Y);
  localparam logic [2:0] LAST_IDX = 3'(NUM_NOTES - 1);

  state_t     st;
  logic [2:0] idx;
  logic [2:0] pattern;
  logic [2:0] hit_mask;

  logic       in_win;
  logic       last_row;
  logic [2:0] hit_now;
  logic [2:0] mask_nxt;
  logic [2:0] unhit_nxt;
  logic [4:0] score_sum;
  logic [4:0] miss_sum;
  logic [3:0] score_nxt;
  logic [3:0] miss_nxt;

  function automatic logic [2:0] pop3(input logic [2:0] v);
    pop3 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]};
  endfunction

  assign note_addr = idx;
  assign state     = st;

  // Hit judgement uses note_y before any same-cycle step increment.
  always_comb begin
    in_win    = (int'(note_y) >= WIN_LO) && (int'(note_y) <= WIN_HI);
    last_row  = step_tick && (note_y == LAST_Y);
    hit_now   = 3'b000;
    if (st == FALL && in_win)
      hit_now = btn & pattern & ~hit_mask;
    mask_nxt  = hit_mask | hit_now;
    unhit_nxt = pattern & ~mask_nxt;
    score_sum = {1'b0, score} + {2'b00, pop3(hit_now)};
    miss_sum  = {1'b0, misses} + {2'b00, pop3(unhit_nxt)};
    score_nxt = (score_sum > 5'd15) ? 4'hf : score_sum[3:0];
    miss_nxt  = (miss_sum > 5'd15) ? 4'hf : miss_sum[3:0];
  end

  // Run sequencer with all outputs registered.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      st           <= IDLE;
      idx          <= 3'd0;
      note_y       <= 10'd0;
      pattern      <= 3'b000;
      hit_mask     <= 3'b000;
      score        <= 4'd0;
      misses       <= 4'd0;
      lane_visible <= 3'b000;
    end else begin
      case (st)
        IDLE: begin
          idx          <= 3'd0;
          score        <= 4'd0;
          misses       <= 4'd0;
          lane_visible <= 3'b000;
          if (start)
            st <= SPAWN;
        end
        SPAWN: begin
          pattern      <= note_data;
          note_y       <= 10'd0;
          hit_mask     <= 3'b000;
          lane_visible <= note_data;
          st           <= FALL;
        end
        FALL: begin
          hit_mask <= mask_nxt;
          score    <= score_nxt;
          if (step_tick)
            note_y <= note_y + 10'd1;
          if (last_row) begin
            misses       <= miss_nxt;
            lane_visible <= 3'b000;
            if (idx == LAST_IDX) begin
              st <= DONE;
            end else begin
              idx <= idx + 3'd1;
              st  <= SPAWN;
            end
          end else begin
            lane_visible <= unhit_nxt;
          end
        end
        DONE: begin
          lane_visible <= 3'b000;
          if (!start)
            st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Directed bench for note_lane_scheduler.
// A second instance with HIT_Y=470 covers the last-row hit case.
module tb_note_lane_scheduler;

  logic       board_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       step_tick = 1'b0;
  logic [2:0] btn = 3'b000;
  logic [2:0] note_addr;
  logic [2:0] note_data;
  logic [9:0] note_y;
  logic [2:0] lane_visible;
  logic [3:0] score;
  logic [3:0] misses;
  logic [1:0] state;

  logic       reset2 = 1'b1;
  logic       start2 = 1'b0;
  logic       tick2 = 1'b0;
  logic [2:0] btn2 = 3'b000;
  logic [2:0] note_addr2;
  logic [2:0] note_data2;
  logic [9:0] note_y2;
  logic [2:0] lane_visible2;
  logic [3:0] score2;
  logic [3:0] misses2;
  logic [1:0] state2;

  logic [2:0] rom [8];
  int total = 0;
  int bad = 0;

  assign note_data  = rom[note_addr];
  assign note_data2 = rom[note_addr2];

  always #5 board_clk = ~board_clk;

  note_lane_scheduler dut (
    .board_clk(board_clk), .reset(reset), .start(start),
    .step_tick(step_tick), .btn(btn), .note_addr(note_addr),
    .note_data(note_data), .note_y(note_y),
    .lane_visible(lane_visible), .score(score),
    .misses(misses), .state(state)
  );

  note_lane_scheduler #(.HIT_Y(470)) dut2 (
    .board_clk(board_clk), .reset(reset2), .start(start2),
    .step_tick(tick2), .btn(btn2), .note_addr(note_addr2),
    .note_data(note_data2), .note_y(note_y2),
    .lane_visible(lane_visible2), .score(score2),
    .misses(misses2), .state(state2)
  );

  task automatic cyc();
    @(posedge board_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    btn = 3'b000;
    step_tick = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic fill_rom(input logic [2:0] v);
    for (int i = 0; i < 8; i++) rom[i] = v;
  endtask

  // Reset, start, and land in FALL with note_y=0.
  task automatic launch();
    do_reset();
    start = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic go_to_y(input int target);
    int n = 0;
    while (int'(note_y) != target && n < 600) begin
      step_tick = 1'b1;
      cyc();
      n++;
    end
    step_tick = 1'b0;
    if (n >= 600) begin
      total++; bad++;
      $display("FAIL go_to_y: got y=%0d want %0d", note_y, target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (state !== 2'b00 || score !== 4'd0 || misses !== 4'd0) begin
      bad++;
      $display("FAIL reset_regs: got st=%b sc=%0d mi=%0d want 00 0 0", state, score, misses);
    end
    total++;
    if (note_y !== 10'd0 || lane_visible !== 3'b000 || note_addr !== 3'd0) begin
      bad++;
      $display("FAIL reset_pos: got y=%0d lv=%b a=%0d want 0 000 0", note_y, lane_visible, note_addr);
    end
    btn = 3'b111;
    cyc();
    btn = 3'b000;
    cyc();
    total++;
    if (state !== 2'b00 || score !== 4'd0) begin
      bad++;
      $display("FAIL idle_hold: got st=%b sc=%0d want 00 0", state, score);
    end
  endtask

  task automatic test_basic();
    int spawns = 1;
    int n = 0;
    rom = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b111, 3'b000};
    do_reset();
    start = 1'b1;
    cyc();
    total++;
    if (state !== 2'b01 || note_addr !== 3'd0) begin
      bad++;
      $display("FAIL first_spawn: got st=%b a=%0d want 01 0", state, note_addr);
    end
    cyc();
    total++;
    if (state !== 2'b10 || note_y !== 10'd0 || lane_visible !== 3'b001) begin
      bad++;
      $display("FAIL first_fall: got st=%b y=%0d lv=%b want 10 0 001", state, note_y, lane_visible);
    end
    start = 1'b0;
    step_tick = 1'b1;
    while (state !== 2'b11 && n < 5000) begin
      cyc();
      if (state === 2'b01) spawns++;
      n++;
    end
    step_tick = 1'b0;
    total++;
    if (state !== 2'b11) begin
      bad++;
      $display("FAIL basic_done: got st=%b want 11", state);
    end
    total++;
    if (spawns != 8 || misses !== 4'd9 || score !== 4'd0) begin
      bad++;
      $display("FAIL basic_count: got sp=%0d mi=%0d sc=%0d want 8 9 0", spawns, misses, score);
    end
    cyc();
    total++;
    if (state !== 2'b00) begin
      bad++;
      $display("FAIL basic_idle: got st=%b want 00", state);
    end
    cyc();
    total++;
    if (misses !== 4'd0 || score !== 4'd0) begin
      bad++;
      $display("FAIL idle_clear: got mi=%0d sc=%0d want 0 0", misses, score);
    end
  endtask

  task automatic test_window();
    fill_rom(3'b111);
    launch();
    start = 1'b0;
    go_to_y(429);
    btn = 3'b001; cyc(); btn = 3'b000;
    total++;
    if (score !== 4'd0) begin
      bad++;
      $display("FAIL win_429: got %0d want 0", score);
    end
    go_to_y(430);
    btn = 3'b010; cyc(); btn = 3'b000;
    total++;
    if (score !== 4'd1) begin
      bad++;
      $display("FAIL win_430: got %0d want 1", score);
    end
    go_to_y(450);
    btn = 3'b100; cyc(); btn = 3'b000;
    total++;
    if (score !== 4'd2) begin
      bad++;
      $display("FAIL win_450: got %0d want 2", score);
    end
    go_to_y(451);
    btn = 3'b001; cyc(); btn = 3'b000;
    total++;
    if (score !== 4'd2 || lane_visible !== 3'b001) begin
      bad++;
      $display("FAIL win_451: got sc=%0d lv=%b want 2 001", score, lane_visible);
    end
    go_to_y(479);
    step_tick = 1'b1; cyc(); step_tick = 1'b0;
    total++;
    if (misses !== 4'd1 || state !== 2'b01 || note_addr !== 3'd1) begin
      bad++;
      $display("FAIL win_end: got mi=%0d st=%b a=%0d want 1 01 1", misses, state, note_addr);
    end
  endtask

  task automatic test_simultaneous();
    fill_rom(3'b111);
    launch();
    go_to_y(440);
    btn = 3'b111; step_tick = 1'b1;
    cyc();
    btn = 3'b000; step_tick = 1'b0;
    total++;
    if (score !== 4'd3 || note_y !== 10'd441 || lane_visible !== 3'b000) begin
      bad++;
      $display("FAIL simul: got sc=%0d y=%0d lv=%b want 3 441 000", score, note_y, lane_visible);
    end
    btn = 3'b111; cyc(); btn = 3'b000;
    total++;
    if (score !== 4'd3) begin
      bad++;
      $display("FAIL simul_repeat: got %0d want 3", score);
    end
  endtask

  task automatic test_saturation();
    int n = 0;
    fill_rom(3'b111);
    launch();
    step_tick = 1'b1;
    while (state !== 2'b11 && n < 5000) begin
      btn = (state === 2'b10 && note_y === 10'd440) ? 3'b111 : 3'b000;
      cyc();
      n++;
    end
    btn = 3'b000;
    total++;
    if (state !== 2'b11 || score !== 4'd15 || misses !== 4'd0) begin
      bad++;
      $display("FAIL sat_hit: got st=%b sc=%0d mi=%0d want 11 15 0", state, score, misses);
    end
    launch();
    n = 0;
    step_tick = 1'b1;
    while (state !== 2'b11 && n < 5000) begin
      cyc();
      n++;
    end
    step_tick = 1'b0;
    total++;
    if (state !== 2'b11 || misses !== 4'd15 || score !== 4'd0) begin
      bad++;
      $display("FAIL sat_miss: got st=%b mi=%0d sc=%0d want 11 15 0", state, misses, score);
    end
  endtask

  task automatic test_last_row();
    int n = 0;
    fill_rom(3'b001);
    reset2 = 1'b1;
    cyc();
    reset2 = 1'b0;
    start2 = 1'b1;
    cyc();
    cyc();
    while (note_y2 !== 10'd479 && n < 600) begin
      tick2 = 1'b1;
      cyc();
      n++;
    end
    btn2 = 3'b001; tick2 = 1'b1;
    cyc();
    btn2 = 3'b000; tick2 = 1'b0;
    total++;
    if (score2 !== 4'd1 || misses2 !== 4'd0 || state2 !== 2'b01) begin
      bad++;
      $display("FAIL last_row: got sc=%0d mi=%0d st=%b want 1 0 01", score2, misses2, state2);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fill_rom(3'b111);
    launch();
    go_to_y(440);
    btn = 3'b111; cyc(); btn = 3'b000;
    step_tick = 1'b1;
    while (state !== 2'b01 && n < 600) begin
      cyc();
      n++;
    end
    cyc();
    go_to_y(200);
    total++;
    if (score !== 4'd3 || note_y !== 10'd200 || note_addr !== 3'd1) begin
      bad++;
      $display("FAIL pre_reset: got sc=%0d y=%0d a=%0d want 3 200 1", score, note_y, note_addr);
    end
    reset = 1'b1;
    #1;
    total++;
    if (state !== 2'b00 || score !== 4'd0 || misses !== 4'd0 || note_y !== 10'd0) begin
      bad++;
      $display("FAIL async_rst: got st=%b sc=%0d mi=%0d y=%0d want 00 0 0 0", state, score, misses, note_y);
    end
    total++;
    if (lane_visible !== 3'b000 || note_addr !== 3'd0) begin
      bad++;
      $display("FAIL async_rst_lane: got lv=%b a=%0d want 000 0", lane_visible, note_addr);
    end
    #2;
    reset = 1'b0;
    start = 1'b1;
    cyc();
    total++;
    if (state !== 2'b01 || note_addr !== 3'd0) begin
      bad++;
      $display("FAIL rst_restart: got st=%b a=%0d want 01 0", state, note_addr);
    end
    start = 1'b0;
  endtask

  initial begin
    fill_rom(3'b000);
    test_reset();
    test_basic();
    test_window();
    test_simultaneous();
    test_saturation();
    test_last_row();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_lane_scheduler.md
NOTE_LANE_SCHEDULER -- requirements
Module: note_lane_scheduler

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  NUM_NOTES  8    entries in note ROM; 1..8
  HIT_Y      440  centre row of hit window
  HIT_WIN    10   hit-window half-width, rows
  END_Y      479  row at which a note row leaves the screen
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  board_clk    in   1   system clock
  reset        in   1   reset, asynchronous, active-high
  start        in   1   level; run request
  step_tick    in   1   one-cycle pulse; advance falling row by 1
  btn          in   3   one-cycle debounced hit pulses, bit i = lane i
  note_addr    out  3   note ROM address
  note_data    in   3   lane pattern at note_addr, combinational, same cycle
  note_y       out  10  current row position of falling notes
  lane_visible out  3   lanes to draw at note_y
  score        out  4   hits, saturating at 15
  misses       out  4   unhit notes, saturating at 15
  state        out  2   00 IDLE, 01 SPAWN, 10 FALL, 11 DONE

Function
REQ-003 SHALL be fully synchronous to board_clk, except for reset.
REQ-004 SHALL drive note_addr from the internal note index idx at all times.
REQ-005 IDLE: SHALL clear idx, score and misses; on start=1 SHALL go to SPAWN next cycle.
REQ-006 SPAWN: single cycle; SHALL load pattern<=note_data, note_y<=0, hit_mask<=000, then go to FALL; pattern 000 (rest) is still scheduled.
REQ-007 FALL: on step_tick SHALL increment note_y by 1; without step_tick note_y holds.
REQ-008 FALL: btn[i] SHALL score when pattern[i]=1, hit_mask[i]=0 and HIT_Y-HIT_WIN <= note_y <= HIT_Y+HIT_WIN (inclusive); it then sets hit_mask[i].
REQ-009 Several qualifying btn bits in one cycle SHALL add their count to score in that cycle; score saturates at 15.
REQ-010 btn outside the window, on an empty lane, on an already-hit lane, or in any state other than FALL SHALL be ignored.
REQ-011 Hit judgement SHALL use note_y before the same-cycle step_tick increment.
REQ-012 FALL with step_tick and note_y=END_Y SHALL add popcount(pattern & ~hit_mask_next) to misses (saturating at 15); hit_mask_next includes same-cycle hits. It SHALL then go to DONE if idx=NUM_NOTES-1, otherwise increment idx and go to SPAWN.
REQ-013 lane_visible SHALL equal pattern & ~hit_mask in FALL and 000 in all other states.
REQ-014 DONE: SHALL hold score, misses and note_y; on start=0 SHALL go to IDLE.
REQ-015 Deasserting start during SPAWN or FALL SHALL NOT abort the run.
REQ-016 All outputs SHALL be registered except note_addr. note_addr is a direct function of the idx register.

Reset
REQ-017 reset=1 SHALL asynchronously force state=IDLE, idx=0, note_y=0, pattern=000, hit_mask=000, score=0, misses=0, lane_visible=000. This holds in every state, including mid-FALL.
REQ-018 After reset deasserts, the block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-019 Basic run: ROM {001,010,100,001,010,100,111,000}, start=1, no btn -> 8 SPAWN/FALL passes, misses=9, score=0, DONE. start=0 -> IDLE.
REQ-020 Window edges: pattern 111, single btn pulses at note_y=429,430,450,451 on lanes 0,1,2,0 respectively -> score=2 (lanes 1,2), lane_visible=001 after them, misses+=1 at END_Y.
REQ-021 Simultaneous events: btn=111 at note_y=440, same cycle as step_tick, pattern 111 -> score+=3, note_y=441, lane_visible=000. A repeat btn=111 -> score unchanged.
REQ-022 Saturation: ROM all 111, all hit -> score stops at 15. Separate run, all missed -> misses stops at 15.
REQ-023 Last-row boundary: btn on lane 0 at note_y=END_Y, same cycle as step_tick, with HIT_Y=470 -> hit counted, not also counted as a miss.
REQ-024 Reset mid-FALL at note_y=200, score=3 -> all outputs zero, state=00 immediately. After release with start=1 -> SPAWN with note_addr=0.
